// File: rtl/mult_pkg.sv
// mult_pkg: shared op encodings, FSM state type and default width for the HI/LO multiply unit
package mult_pkg;
  localparam int MULT_WIDTH = 32;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MADDU = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;
  typedef enum logic [1:0] {IDLE, MUL, COMMIT} state_t;
endpackage

// File: rtl/multiplier.sv
// multiplier: combinational unsigned WIDTHxWIDTH array multiplier
//   in1, in2 : unsigned operands
//   out      : full 2*WIDTH-bit product
module multiplier #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic [2*WIDTH-1:0] out
);
  assign out = (2*WIDTH)'(in1) * (2*WIDTH)'(in2);
endmodule

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: multi-cycle HI/LO multiply/accumulate wrapper around the combinational multiplier
//   clk, rst_n : clock, asynchronous active-low reset
//   start, op  : request strobe and operation (MULTU, MADDU, MTHI, MTLO)
//   in1, in2   : unsigned operands (in2 unused by MTHI/MTLO)
//   busy       : multiply in flight
//   done       : one-cycle pulse after HI/LO was updated
//   hi, lo     : architectural HI/LO registers
module hilo_mult_unit import mult_pkg::*; #(
  parameter int WIDTH = MULT_WIDTH,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t state, next_state;
  logic [3:0] cnt;
  logic [WIDTH-1:0] a, b;
  logic madd;
  logic [2*WIDTH-1:0] prod;
  logic accept_mul, accept_mt;
  multiplier #(.WIDTH(WIDTH)) u_mul (.in1(a), .in2(b), .out(prod));
  assign busy = state != IDLE;
  always_comb begin
    accept_mul = state == IDLE && start && (op == OP_MULTU || op == OP_MADDU);
    accept_mt = state == IDLE && start && (op == OP_MTHI || op == OP_MTLO);
    next_state = state;
    unique case (state)
      IDLE:    next_state = accept_mul ? MUL : IDLE;
      MUL:     next_state = cnt == '0 ? COMMIT : MUL;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      a <= '0;
      b <= '0;
      madd <= 1'b0;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
    end else begin
      state <= next_state;
      done <= state == COMMIT || accept_mt;
      if (accept_mul) begin
        a <= in1;
        b <= in2;
        madd <= op == OP_MADDU;
        cnt <= 4'(LAT - 1);
      end else if (state == MUL && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      // accumulate wraps modulo 2^(2*WIDTH); carry-out dropped
      if (state == COMMIT) {hi, lo} <= madd ? {hi, lo} + prod : prod;
      else if (accept_mt && op == OP_MTHI) hi <= in1;
      else if (accept_mt && op == OP_MTLO) lo <= in1;
    end
  end
endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb_hilo_mult_unit: self-checking bench for hilo_mult_unit (LAT=2 main instance, LAT=1 corner instance)
module tb_hilo_mult_unit;
  localparam int LAT = 2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_l1 = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] in1 = '0, in2 = '0;
  logic busy, done, busy_l1, done_l1;
  logic [31:0] hi, lo, hi_l1, lo_l1;
  int checks = 0, failures = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_prod;
  logic m_madd, m_done;
  int m_rem;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
  } vec_t;
  vec_t vecs[9];

  hilo_mult_unit #(.WIDTH(32), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  hilo_mult_unit #(.WIDTH(32), .LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .start(start_l1), .op(op), .in1(in1), .in2(in2),
    .busy(busy_l1), .done(done_l1), .hi(hi_l1), .lo(lo_l1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_hi = '0; m_lo = '0; m_prod = '0; m_madd = 1'b0; m_done = 1'b0; m_rem = 0;
  endfunction

  // cycle-count model: a multiply finishes LAT+1 edges after acceptance
  function automatic void model_edge(input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    m_done = 1'b0;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        {m_hi, m_lo} = m_madd ? {m_hi, m_lo} + m_prod : m_prod;
        m_done = 1'b1;
      end
    end else if (s) begin
      if (o == 2'b10) m_hi = x;
      else if (o == 2'b11) m_lo = x;
      else begin
        m_prod = 64'(x) * 64'(y);
        m_madd = o == 2'b01;
        m_rem = LAT + 1;
      end
      if (o[1]) m_done = 1'b1;
    end
  endfunction

  task automatic step(input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = s; op = o; in1 = x; in2 = y;
    @(posedge clk);
    model_edge(s, o, x, y);
    #1;
    start = 1'b0;
    chk("model_hi", 64'(hi), 64'(m_hi));
    chk("model_lo", 64'(lo), 64'(m_lo));
    chk("model_busy", 64'(busy), 64'(m_rem > 0));
    chk("model_done", 64'(done), 64'(m_done));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return 32'hFFFF_FFFF;
      1: return 32'(($urandom_range(0, 1)) ? 0 : 1);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nb, k;
    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b10, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0000_0001};
    vecs[2] = '{2'b11, 32'h9ABC_DEF0, 32'h5, 32'h1234_5678, 32'h9ABC_DEF0};
    vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h9ABC_DEF0};
    vecs[4] = '{2'b11, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5] = '{2'b01, 32'h1, 32'h1, 32'h0, 32'h0};
    vecs[6] = '{2'b00, 32'h3, 32'h4, 32'h0, 32'hC};
    vecs[7] = '{2'b01, 32'h1_0000, 32'h1_0000, 32'h1, 32'hC};
    vecs[8] = '{2'b00, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};
    model_reset();
    #12;
    chk("reset_hi", 64'(hi), 0);
    chk("reset_lo", 64'(lo), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // reset mid-MUL discards the multiply and clears HI/LO at once
    step(1'b1, 2'b10, 32'hAAAA_0000, 32'h0);
    step(1'b1, 2'b00, 32'd5, 32'd7);
    step(1'b0, 2'b00, 32'h0, 32'h0);
    chk("pre_reset_busy", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_hi", 64'(hi), 0);
    chk("async_reset_lo", 64'(lo), 0);
    chk("async_reset_busy", 64'(busy), 0);
    chk("async_reset_done", 64'(done), 0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 2'b00, 32'h0, 32'h0);

    // table: one full operation per entry, busy length and final HI/LO
    for (int i = 0; i < 9; i++) begin
      step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      nb = 0; k = 0;
      while (!done && k < 20) begin
        if (busy) nb++;
        step(1'b0, 2'b00, 32'h0, 32'h0);
        k++;
      end
      chk($sformatf("vec%0d_done", i), 64'(done), 1);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(nb), vecs[i].op[1] ? 0 : LAT + 1);
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].exp_hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].exp_lo));
      step(1'b0, 2'b00, 32'h0, 32'h0);
      chk($sformatf("vec%0d_done_drop", i), 64'(done), 0);
    end

    // back-to-back MTHI/MTLO
    step(1'b1, 2'b10, 32'h1234_5678, 32'h0);
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_done", 64'(done), 1);
    step(1'b1, 2'b11, 32'h9ABC_DEF0, 32'h0);
    chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
    chk("mtlo_done", 64'(done), 1);
    chk("mt_busy", 64'(busy), 0);
    step(1'b0, 2'b00, 32'h0, 32'h0);

    // start held through MUL and the commit edge
    step(1'b1, 2'b00, 32'd3, 32'd4);
    for (int i = 0; i < LAT + 1; i++) step(1'b1, 2'(i % 2), $urandom, $urandom);
    chk("held_lo", 64'(lo), 12);
    chk("held_hi", 64'(hi), 0);
    chk("held_done", 64'(done), 1);
    chk("held_busy_low", 64'(busy), 0);
    step(1'b1, 2'b00, 32'd6, 32'd7);
    chk("held_next_accept", 64'(busy), 1);
    for (int i = 0; i < LAT + 2; i++) step(1'b0, 2'b00, 32'h0, 32'h0);
    chk("held_next_lo", 64'(lo), 42);

    // LAT=1 instance: commit two edges after acceptance
    start_l1 = 1'b1; op = 2'b00; in1 = 32'h1_0000; in2 = 32'h1_0000;
    @(posedge clk); #1;
    start_l1 = 1'b0; in1 = '0; in2 = '0;
    chk("l1_busy_t0", 64'(busy_l1), 1);
    chk("l1_done_t0", 64'(done_l1), 0);
    @(posedge clk); #1;
    chk("l1_busy_t1", 64'(busy_l1), 1);
    chk("l1_done_t1", 64'(done_l1), 0);
    @(posedge clk); #1;
    chk("l1_hi", 64'(hi_l1), 1);
    chk("l1_lo", 64'(lo_l1), 0);
    chk("l1_done_t2", 64'(done_l1), 1);
    chk("l1_busy_t2", 64'(busy_l1), 0);
    @(posedge clk); #1;
    chk("l1_done_t3", 64'(done_l1), 0);
    m_done = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), pick(), pick());
    for (int i = 0; i < LAT + 3; i++) step(1'b0, 2'b00, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hilo_mult_unit.md
# hilo_mult_unit

- Multi-cycle wrapper that sits directly downstream of the combinational `multiplier` (32x32 unsigned, 64-bit product).
- Accepts operand/op requests and registers the operands in front of the multiplier.
- Waits a fixed latency so the product settles through the combinational array, then commits the 64-bit result into architectural HI/LO registers.
- Also services direct HI/LO writes (MTHI/MTLO) for the datapath.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. The product is 2*WIDTH.
- `LAT`, default 2: cycles from request acceptance to HI/LO commit. Legal range 1..15.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: the single clock; all state on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe, sampled on the rising edge.
- `op` in 2: operation select.
  - 00 MULTU: {hi,lo} = in1*in2.
  - 01 MADDU: {hi,lo} += in1*in2.
  - 10 MTHI: hi = in1.
  - 11 MTLO: lo = in1.
- `in1` in WIDTH: operand A, unsigned.
- `in2` in WIDTH: operand B, unsigned; ignored for MTHI/MTLO.
- `busy` out 1: high while a multiply is in flight.
- `done` out 1: one-cycle pulse when HI/LO has been updated.
- `hi` out WIDTH: HI register, the upper product half.
- `lo` out WIDTH: LO register, the lower product half.

## Operation

- **Reset:** `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM in IDLE, counter=0, operand registers=0. Reset takes effect immediately, even mid-operation; an in-flight multiply is discarded and nothing is committed.
- **FSM states:** IDLE, MUL, COMMIT.
- **In IDLE:**
  - `start` with op MULTU or MADDU: latch in1/in2/op into the operand registers, load counter=LAT-1, go to MUL.
  - `start` with op MTHI/MTLO: write `hi` or `lo` from in1 on that edge, pulse `done`, stay in IDLE.
- **In MUL:**
  - The operand registers drive the `multiplier` sub-module; the counter decrements each cycle.
  - When counter==0, go to COMMIT.
  - For LAT=1, go directly to COMMIT on the next edge.
- **In COMMIT (one cycle):**
  - On the exiting edge, write {hi,lo} = product for MULTU, or {hi,lo} + product for MADDU.
  - Pulse `done`, return to IDLE.
- **Arithmetic:**
  - Fully unsigned.
  - MADDU addition is 2*WIDTH bits, modulo 2^(2*WIDTH); carry-out is dropped.
  - MADDU uses the HI/LO value at the commit edge. Nothing else can write HI/LO while busy, so this equals the value at acceptance.
- **`start` while busy:**
  - Ignored entirely, including MTHI/MTLO.
  - Not queued; the requester must hold `start` until it sees `busy` low.
- **`start` on the same edge that leaves COMMIT:** ignored. The FSM is not in IDLE at that edge, so a new request is accepted at the earliest on the next edge.
- **Input changes after acceptance:** changes to in1/in2 have no effect, because the operands are registered.

## Timing

- Acceptance edge T0. `busy`=1 from after T0 until after the commit edge.
- The commit edge is T0+LAT+1, counting MUL cycles plus the COMMIT cycle.
- At T0+LAT+1, `hi`/`lo` update, `busy` falls, and `done` is high for exactly the following cycle.
- Throughput: one multiply per LAT+2 cycles, counting the IDLE acceptance cycle.
- MTHI/MTLO: zero-wait.
  - The register updates at T0.
  - `done`=1 for the cycle after T0.
  - `busy` stays 0.
- `busy`, `done`, `hi` and `lo` are all registered outputs, with no combinational path from inputs.

## Structure

- **Shared package** `mult_pkg`:
  - op encodings `OP_MULTU`, `OP_MADDU`, `OP_MTHI`, `OP_MTLO`;
  - FSM state typedef (IDLE/MUL/COMMIT);
  - `WIDTH` default constant.
- **Sub-module:** exactly one, the existing `multiplier` (ports `in1`, `in2`, `out`), instantiated on the operand registers.
- **Control and accumulate logic:** the FSM, counter, accumulate adder and HI/LO registers all live in `hilo_mult_unit`.

## Test plan

1. Reset mid-MUL (start MULTU 5*7, assert `rst_n`=0 one cycle later):
   - `hi`=`lo`=0 and `busy`=0 immediately;
   - no `done` pulse after release.
2. MULTU, LAT=2, in1=0xFFFFFFFF, in2=0xFFFFFFFF:
   - `busy` high 3 cycles;
   - `hi`=0xFFFFFFFE, `lo`=0x00000001;
   - `done` pulses once.
3. MTHI in1=0x12345678, then MTLO in1=0x9ABCDEF0 on consecutive cycles:
   - each register updates on its own edge;
   - `done` pulses twice;
   - `busy` stays 0.
4. MADDU wrap, after MTHI 0xFFFFFFFF and MTLO 0xFFFFFFFF, do MADDU 1*1:
   - {hi,lo}=0 (modulo wrap);
   - no other flag.
5. `start` held high with different operands every cycle during MUL (first request MULTU 3*4):
   - only the first request commits, giving `lo`=12, `hi`=0;
   - a request presented on the commit edge is not accepted;
   - the next request is accepted on the cycle after `busy` falls.
6. LAT=1 build, MULTU 0x10000*0x10000:
   - `hi`=1, `lo`=0 at T0+2;
   - `done` high in cycle T0+2..T0+3.
